axo_mem_arbiter: RTL and testbench
==================================

# axo_mem_arbiter

Two-port to one-port memory arbiter for the axo_rv32i core. It lets the core's instruction-fetch port (`prog_*`) and data port (`mem_*`) share a single-ported memory. Each access is sequenced through a request/grant/response state machine. Data accesses have priority, and a starvation counter guarantees forward progress for instruction fetch. The block sits between the CPU and the system memory; the CPU's ready inputs are driven from this block instead of being tied high.

## Interface

Parameters:
- `STARVE_LIMIT`, default 4: maximum consecutive data grants made while a fetch is pending. Legal range is 1..15.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `d_re`  in  1  CPU data read request.
- `d_we`  in  1  CPU data write request.
- `d_asize`  in  2  data access size: 00 byte, 01 half, 10 word.
- `d_addr`  in  32  data address.
- `d_wdata`  in  32  data write value.
- `d_rdata`  out  32  data read value; valid while `d_ready` is high.
- `d_ready`  out  1  one-cycle completion pulse for a data access.
- `p_re`  in  1  instruction fetch request.
- `p_addr`  in  32  fetch address.
- `p_rdata`  out  32  fetched word; valid while `p_ready` is high.
- `p_ready`  out  1  one-cycle completion pulse for a fetch.
- `m_re`, `m_we`  out  1  shared-memory read/write strobes.
- `m_asize`  out  2  shared-memory access size.
- `m_addr`  out  32  shared-memory address.
- `m_wdata`  out  32  shared-memory write value.
- `m_rdata`  in  32  shared-memory read value; sampled when `m_ready` is high.
- `m_ready`  in  1  shared-memory completion; may be tied high.

## Operation

- States:
  - IDLE: no access in progress.
  - BUSY: a memory access is being driven.
  - RESP: the completion pulse is being returned to the requester.
- IDLE:
  - If `d_re|d_we` or `p_re` is high, pick a winner.
  - Latch the winner's address, size and write data into internal registers, plus the direction and grant identity.
  - Go to BUSY.
  - With no request, stay in IDLE.
- Winner selection:
  - The data port wins, unless `p_re` is pending and `starve_cnt == STARVE_LIMIT`; in that case the fetch port wins.
- `starve_cnt` (4 bits):
  - Increments on a data grant while `p_re` is high.
  - Clears on any fetch grant.
  - Clears on a data grant while `p_re` is low.
  - Saturates at `STARVE_LIMIT`.
- Request qualification:
  - If `d_re` and `d_we` are both high, the access is a write: `m_we=1`, `m_re=0`.
  - A fetch is always a word read: `m_asize=2'b10`, `m_wdata=0`.
- BUSY:
  - Drive `m_re`/`m_we`/`m_asize`/`m_addr`/`m_wdata` from the latched registers, held stable for every BUSY cycle.
  - When `m_ready` is high, capture `m_rdata` into the shared read register (write accesses capture it too; the value is don't-care) and go to RESP.
- RESP:
  - `m_re=m_we=0`.
  - Assert exactly one of `d_ready` or `p_ready` for the granted port.
  - Both `d_rdata` and `p_rdata` are driven from the shared read register.
  - Next state is IDLE.
- Requester contract:
  - A requester holds its request, address and data stable until it sees its ready pulse.
  - It deasserts the request on the edge that ends RESP.
  - The IDLE cycle after RESP guarantees a stale request is never regranted.
- Address bits are passed through unaltered. The arbiter does no alignment checking.

## Timing

- Reset values:
  - All outputs 0; state IDLE; `starve_cnt=0`; read register 0.
  - Reset is applied asynchronously and released synchronously to `clk` by the surrounding design.
- Reset mid-BUSY or mid-RESP: the access is abandoned and no ready pulse is issued. The memory must tolerate `m_re`/`m_we` dropping without completion.
- Latency, with the request first seen high in IDLE at edge 0:
  - Memory strobes are asserted from edge 0 to edge N, where N is the first BUSY edge with `m_ready=1`.
  - The ready pulse is high for the single cycle after edge N.
- Zero-wait memory (`m_ready` tied high):
  - Strobes are high in cycle 1.
  - Ready is high in cycle 2.
  - Minimum service interval is 3 cycles per access.
- Simultaneous `d_*` and `p_re` in IDLE: one grant per IDLE cycle. The loser's request stays pending and is evaluated in the next IDLE.
- `m_ready` seen outside BUSY is ignored.

## Test plan

- Reset: deassert `rst_n` in the middle of BUSY.
  - All outputs go to 0 immediately.
  - After release, no `p_ready`/`d_ready` pulse occurs without a new request.
- Single fetch, with `m_ready=1`, `p_addr=0x4`, `m_rdata=0x00108133`:
  - Cycle 1: `m_re=1`, `m_addr=0x4`, `m_asize=10`.
  - Cycle 2: `p_ready=1`, `p_rdata=0x00108133`.
- Contention: `p_re` (addr 0x8) and `d_we` (addr 0x100, `d_wdata=0xF00DCABE`, `d_asize=10`) asserted together.
  - Data write is served first: `m_we=1`, `m_wdata=0xF00DCABE`, then `d_ready`.
  - The fetch of 0x8 follows, then `p_ready`.
- Wait states: `d_re` at addr 0x200 with `m_ready` held low 3 cycles, then `m_rdata=0xABE20213` with `m_ready` high.
  - `m_*` outputs stay constant for 4 BUSY cycles.
  - `d_ready=1` with `d_rdata=0xABE20213` exactly one cycle later.
- Starvation: `STARVE_LIMIT=2`, `d_re` reissued continuously, `p_re` held.
  - Grant order is D, D, P, D, D, P.
  - `starve_cnt` reads 0 after each P grant.
- Conflicting strobes: `d_re=d_we=1`.
  - Memory sees `m_we=1` and `m_re=0`.
  - `d_ready` pulses once.

Source files
------------

// File: rtl/axo_mem_arbiter.sv
// Shares one single-ported memory between the core's data port and instruction-fetch port.
// Data accesses have priority; a starvation counter bounds how long a pending fetch can wait.
module axo_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        d_re,
    input  logic        d_we,
    input  logic [1:0]  d_asize,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    input  logic        p_re,
    input  logic [31:0] p_addr,
    output logic [31:0] p_rdata,
    output logic        p_ready,
    output logic        m_re,
    output logic        m_we,
    output logic [1:0]  m_asize,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  asize_q, asize_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        gnt_p_q, gnt_p_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        d_req;
    logic        busy;

    assign d_req = d_re | d_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            asize_q      <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            gnt_p_q      <= 1'b0;
            rdata_q      <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            asize_q      <= asize_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            gnt_p_q      <= gnt_p_d;
            rdata_q      <= rdata_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        asize_d      = asize_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        gnt_p_d      = gnt_p_q;
        rdata_d      = rdata_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            IDLE: begin
                if (d_req || p_re) begin
                    state_d = BUSY;
                    // Fetch wins only when data is idle or data has hit its grant quota.
                    if (p_re && (!d_req || starve_cnt_q == LIMIT)) begin
                        addr_d       = p_addr;
                        asize_d      = 2'b10;
                        wdata_d      = '0;
                        we_d         = 1'b0;
                        gnt_p_d      = 1'b1;
                        starve_cnt_d = '0;
                    end else begin
                        addr_d       = d_addr;
                        asize_d      = d_asize;
                        wdata_d      = d_wdata;
                        we_d         = d_we;
                        gnt_p_d      = 1'b0;
                        if (!p_re)
                            starve_cnt_d = '0;
                        else if (starve_cnt_q != LIMIT)
                            starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end
            end
            BUSY: begin
                if (m_ready) begin
                    rdata_d = m_rdata;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory side is quiet outside BUSY so reset and RESP both show all-zero strobes.
    assign busy    = (state_q == BUSY);
    assign m_re    = busy & ~we_q;
    assign m_we    = busy & we_q;
    assign m_asize = busy ? asize_q : 2'b00;
    assign m_addr  = busy ? addr_q  : 32'h0;
    assign m_wdata = busy ? wdata_q : 32'h0;

    assign d_ready = (state_q == RESP) & ~gnt_p_q;
    assign p_ready = (state_q == RESP) &  gnt_p_q;
    assign d_rdata = rdata_q;
    assign p_rdata = rdata_q;

endmodule

// File: tb/tb_axo_mem_arbiter.sv
// Directed bench for axo_mem_arbiter: table-driven single transactions plus
// hand-written contention, wait-state, starvation and reset sequences.
module tb_axo_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d_re, d_we;
    logic [1:0]  d_asize;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_ready;
    logic        p_re;
    logic [31:0] p_addr, p_rdata;
    logic        p_ready;
    logic        m_re, m_we;
    logic [1:0]  m_asize;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_ready;

    int checks = 0;
    int errors = 0;

    axo_mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_re(d_re), .d_we(d_we), .d_asize(d_asize), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .p_re(p_re), .p_addr(p_addr), .p_rdata(p_rdata), .p_ready(p_ready),
        .m_re(m_re), .m_we(m_we), .m_asize(m_asize), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        d_re, d_we;
        logic [1:0]  d_asize;
        logic [31:0] d_addr, d_wdata;
        logic        p_re;
        logic [31:0] p_addr, m_rdata;
        logic        e_re, e_we;
        logic [1:0]  e_asize;
        logic [31:0] e_addr, e_wdata;
        logic        e_port;   // 1 = fetch port gets the ready pulse
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        d_re = 1'b0; d_we = 1'b0; d_asize = 2'b00; d_addr = '0; d_wdata = '0;
        p_re = 1'b0; p_addr = '0;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_strb"}, {29'd0, m_re, m_we, 1'b0}, 32'd0);
        chk({nm, "_rdy"}, {30'd0, d_ready, p_ready}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{"fetch4",  0, 0, 2'b00, 32'h0,    32'h0,        1, 32'h4,  32'h00108133,
                    1, 0, 2'b10, 32'h4,    32'h0,        1};
        vecs[1] = '{"rd_byte", 1, 0, 2'b00, 32'h1003, 32'hDEADBEEF, 0, 32'h0,  32'h000000A5,
                    1, 0, 2'b00, 32'h1003, 32'hDEADBEEF, 0};
        vecs[2] = '{"wr_half", 0, 1, 2'b01, 32'h2002, 32'h0000BEEF, 0, 32'h0,  32'h11111111,
                    0, 1, 2'b01, 32'h2002, 32'h0000BEEF, 0};
        vecs[3] = '{"wr_word", 0, 1, 2'b10, 32'h100,  32'hF00DCABE, 0, 32'h0,  32'h22222222,
                    0, 1, 2'b10, 32'h100,  32'hF00DCABE, 0};
        vecs[4] = '{"conflict",1, 1, 2'b10, 32'h400,  32'h12345678, 0, 32'h0,  32'h33333333,
                    0, 1, 2'b10, 32'h400,  32'h12345678, 0};
        vecs[5] = '{"fetch80", 0, 0, 2'b01, 32'h999,  32'hFFFFFFFF, 1, 32'h80, 32'h44444444,
                    1, 0, 2'b10, 32'h80,   32'h0,        1};

        rst_n = 1'b0; m_ready = 1'b1; m_rdata = '0;
        clear_req();
        #12;
        chk("rst_mstrb", {29'd0, m_re, m_we, m_asize}, 32'd0);
        chk("rst_maddr", m_addr, 32'd0);
        chk("rst_mwdata", m_wdata, 32'd0);
        chk("rst_drdata", d_rdata, 32'd0);
        chk("rst_prdata", p_rdata, 32'd0);
        chk("rst_rdy", {30'd0, d_ready, p_ready}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Table-driven zero-wait transactions: IDLE -> BUSY -> RESP -> IDLE
        for (int i = 0; i < 6; i++) begin
            d_re = vecs[i].d_re; d_we = vecs[i].d_we; d_asize = vecs[i].d_asize;
            d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
            p_re = vecs[i].p_re; p_addr = vecs[i].p_addr; m_rdata = vecs[i].m_rdata;
            tick();
            chk({vecs[i].name, "_mre"}, {31'd0, m_re}, {31'd0, vecs[i].e_re});
            chk({vecs[i].name, "_mwe"}, {31'd0, m_we}, {31'd0, vecs[i].e_we});
            chk({vecs[i].name, "_asize"}, {30'd0, m_asize}, {30'd0, vecs[i].e_asize});
            chk({vecs[i].name, "_maddr"}, m_addr, vecs[i].e_addr);
            chk({vecs[i].name, "_mwdata"}, m_wdata, vecs[i].e_wdata);
            chk({vecs[i].name, "_busyrdy"}, {30'd0, d_ready, p_ready}, 32'd0);
            tick();
            chk({vecs[i].name, "_respstrb"}, {30'd0, m_re, m_we}, 32'd0);
            chk({vecs[i].name, "_rdy"}, {30'd0, d_ready, p_ready},
                vecs[i].e_port ? 32'd1 : 32'd2);
            chk({vecs[i].name, "_rdata"}, vecs[i].e_port ? p_rdata : d_rdata, vecs[i].m_rdata);
            clear_req();
            tick();
            chk_quiet({vecs[i].name, "_idle"});
        end

        // Contention: data write first, then the pending fetch
        d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hF00DCABE; d_asize = 2'b10;
        p_re = 1'b1; p_addr = 32'h8; m_rdata = 32'h00000013;
        tick();
        chk("cont_mwe", {30'd0, m_re, m_we}, 32'd1);
        chk("cont_maddr", m_addr, 32'h100);
        chk("cont_mwdata", m_wdata, 32'hF00DCABE);
        tick();
        chk("cont_drdy", {30'd0, d_ready, p_ready}, 32'd2);
        d_we = 1'b0; d_addr = '0; d_wdata = '0; d_asize = 2'b00;
        tick();
        chk_quiet("cont_idle");
        tick();
        chk("cont_pre", {30'd0, m_re, m_we}, 32'd2);
        chk("cont_paddr", m_addr, 32'h8);
        chk("cont_pasize", {30'd0, m_asize}, 32'd2);
        chk("cont_pwdata", m_wdata, 32'd0);
        tick();
        chk("cont_prdy", {30'd0, d_ready, p_ready}, 32'd1);
        chk("cont_prdata", p_rdata, 32'h00000013);
        clear_req();
        tick();
        chk_quiet("cont_end");

        // Wait states: m_ready low for three BUSY cycles
        d_re = 1'b1; d_addr = 32'h200; d_asize = 2'b10; m_ready = 1'b0; m_rdata = 32'h55555555;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("ws_mre", {30'd0, m_re, m_we}, 32'd2);
            chk("ws_maddr", m_addr, 32'h200);
            chk("ws_asize", {30'd0, m_asize}, 32'd2);
            chk("ws_rdy", {30'd0, d_ready, p_ready}, 32'd0);
        end
        m_ready = 1'b1; m_rdata = 32'hABE20213;
        tick();
        chk("ws_drdy", {30'd0, d_ready, p_ready}, 32'd2);
        chk("ws_rdata", d_rdata, 32'hABE20213);
        clear_req();
        tick();
        chk_quiet("ws_end");

        // Reset in the middle of BUSY
        d_re = 1'b1; d_addr = 32'h300; d_asize = 2'b01; m_ready = 1'b0;
        tick();
        chk("mrst_busy", {31'd0, m_re}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_mstrb", {29'd0, m_re, m_we, m_asize}, 32'd0);
        chk("mrst_maddr", m_addr, 32'd0);
        chk("mrst_rdata", d_rdata | p_rdata, 32'd0);
        chk("mrst_rdy", {30'd0, d_ready, p_ready}, 32'd0);
        clear_req();
        m_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_quiet("mrst_after");
        end

        // Starvation with STARVE_LIMIT=2: D, D, P, D, D, P
        d_re = 1'b1; d_addr = 32'h500; d_asize = 2'b10; p_re = 1'b1; p_addr = 32'h40;
        for (int g = 0; g < 6; g++) begin
            logic is_p;
            is_p = (g == 2) || (g == 5);
            m_rdata = 32'hC0DE0000 + g;
            tick();
            chk("stv_addr", m_addr, is_p ? 32'h40 : 32'h500);
            if (is_p)
                chk("stv_cnt", {28'd0, dut.starve_cnt_q}, 32'd0);
            tick();
            chk("stv_rdy", {30'd0, d_ready, p_ready}, is_p ? 32'd1 : 32'd2);
            tick();
        end
        clear_req();
        tick();
        chk_quiet("stv_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
